// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes and SRAM pins shared by the ULA, CPU and tape loader.
// slave = the arbiter's view, master = the requesters plus the memory device.
interface ram_arbiter_if;
  logic        phi2;
  logic        vid_req;
  logic [15:0] vid_ad;
  logic [7:0]  vid_q;
  logic        vid_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_ad;
  logic [7:0]  cpu_d;
  logic [7:0]  cpu_q;
  logic        cpu_valid;
  logic        dma_req;
  logic [15:0] dma_ad;
  logic [7:0]  dma_d;
  logic        dma_ack;
  logic [15:0] ram_ad;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q;
  logic        ram_cs;
  logic        ram_oe;
  logic        ram_we;

  modport slave (
    input  phi2, vid_req, vid_ad, cpu_req, cpu_we, cpu_ad, cpu_d,
           dma_req, dma_ad, dma_d, ram_q,
    output vid_q, vid_valid, cpu_q, cpu_valid, dma_ack,
           ram_ad, ram_d, ram_cs, ram_oe, ram_we
  );

  modport master (
    output phi2, vid_req, vid_ad, cpu_req, cpu_we, cpu_ad, cpu_d,
           dma_req, dma_ad, dma_d, ram_q,
    input  vid_q, vid_valid, cpu_q, cpu_valid, dma_ack,
           ram_ad, ram_d, ram_cs, ram_oe, ram_we
  );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port SRAM arbiter between ULA video fetch, CPU and tape-loader DMA.
// Every access is a fixed two-cycle ACC1/ACC2 pair; results are strobed the cycle after ACC2.
module ram_arbiter #(
  parameter int unsigned DMA_MAX_WAIT = 15
) (
  input  logic         CLK_IN,
  input  logic         RESETn,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC1 = 2'd1, ACC2 = 2'd2} state_t;
  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_VID = 2'd1, SRC_CPU = 2'd2, SRC_DMA = 2'd3} src_t;

  state_t      state_r;
  src_t        owner_r;
  logic        write_r;
  logic [3:0]  wait_cnt_r;
  logic [15:0] ram_ad_r;
  logic [7:0]  ram_d_r;
  logic        ram_cs_r;
  logic        ram_oe_r;
  logic        ram_we_r;
  logic [7:0]  vid_q_r;
  logic [7:0]  cpu_q_r;
  logic        vid_valid_r;
  logic        cpu_valid_r;
  logic        dma_ack_r;

  logic        arb_slot_s;
  logic        dma_promote_s;
  src_t        winner_s;
  logic        win_write_s;
  logic [15:0] win_ad_s;
  logic [7:0]  win_d_s;

  // Pick this slot's winner and the address/data it would latch.
  always_comb begin
    arb_slot_s    = (state_r == IDLE) || (state_r == ACC2);
    dma_promote_s = ({28'd0, wait_cnt_r} == DMA_MAX_WAIT);
    winner_s      = SRC_NONE;
    win_write_s   = 1'b0;
    win_ad_s      = ram_ad_r;
    win_d_s       = ram_d_r;
    if (!arb_slot_s) begin
      winner_s = SRC_NONE;
    end else if (!bus.phi2) begin
      // Video phase: the CPU is not allowed on the bus at all.
      if (bus.vid_req) begin
        winner_s = SRC_VID;
      end else if (bus.dma_req) begin
        winner_s = SRC_DMA;
      end else begin
        winner_s = SRC_NONE;
      end
    end else begin
      if (bus.dma_req && dma_promote_s) begin
        winner_s = SRC_DMA;
      end else if (bus.cpu_req) begin
        winner_s = SRC_CPU;
      end else if (bus.dma_req) begin
        winner_s = SRC_DMA;
      end else begin
        winner_s = SRC_NONE;
      end
    end
    case (winner_s)
      SRC_VID: begin
        win_ad_s    = bus.vid_ad;
        win_write_s = 1'b0;
      end
      SRC_CPU: begin
        win_ad_s    = bus.cpu_ad;
        win_write_s = bus.cpu_we;
        if (bus.cpu_we) begin
          win_d_s = bus.cpu_d;
        end else begin
          win_d_s = ram_d_r;
        end
      end
      SRC_DMA: begin
        win_ad_s    = bus.dma_ad;
        win_write_s = 1'b1;
        win_d_s     = bus.dma_d;
      end
      default: begin
        win_ad_s    = ram_ad_r;
        win_write_s = 1'b0;
        win_d_s     = ram_d_r;
      end
    endcase
  end

  // Access sequencer, DMA starvation counter and all registered outputs.
  always_ff @(posedge CLK_IN or negedge RESETn) begin
    if (!RESETn) begin
      state_r     <= IDLE;
      owner_r     <= SRC_NONE;
      write_r     <= 1'b0;
      wait_cnt_r  <= 4'd0;
      ram_ad_r    <= 16'h0000;
      ram_d_r     <= 8'h00;
      ram_cs_r    <= 1'b0;
      ram_oe_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      vid_q_r     <= 8'h00;
      cpu_q_r     <= 8'h00;
      vid_valid_r <= 1'b0;
      cpu_valid_r <= 1'b0;
      dma_ack_r   <= 1'b0;
    end else begin
      vid_valid_r <= 1'b0;
      cpu_valid_r <= 1'b0;
      dma_ack_r   <= 1'b0;
      if (state_r == ACC2) begin
        case (owner_r)
          SRC_VID: begin
            vid_valid_r <= 1'b1;
            vid_q_r     <= bus.ram_q;
          end
          SRC_CPU: begin
            cpu_valid_r <= 1'b1;
            if (!write_r) begin
              cpu_q_r <= bus.ram_q;
            end else begin
              cpu_q_r <= cpu_q_r;
            end
          end
          SRC_DMA: dma_ack_r <= 1'b1;
          default: dma_ack_r <= 1'b0;
        endcase
      end else begin
        dma_ack_r <= 1'b0;
      end

      if (!bus.dma_req || (winner_s == SRC_DMA)) begin
        wait_cnt_r <= 4'd0;
      end else if (arb_slot_s && (wait_cnt_r != 4'hF)) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end

      case (state_r)
        IDLE, ACC2: begin
          if (winner_s != SRC_NONE) begin
            state_r  <= ACC1;
            owner_r  <= winner_s;
            write_r  <= win_write_s;
            ram_ad_r <= win_ad_s;
            ram_d_r  <= win_d_s;
            ram_cs_r <= 1'b1;
            ram_oe_r <= !win_write_s;
            ram_we_r <= 1'b0;
          end else begin
            state_r  <= IDLE;
            owner_r  <= SRC_NONE;
            ram_cs_r <= 1'b0;
            ram_oe_r <= 1'b0;
            ram_we_r <= 1'b0;
          end
        end
        ACC1: begin
          state_r  <= ACC2;
          ram_we_r <= write_r;
        end
        default: begin
          state_r  <= IDLE;
          owner_r  <= SRC_NONE;
          ram_cs_r <= 1'b0;
          ram_oe_r <= 1'b0;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_ad    = ram_ad_r;
  assign bus.ram_d     = ram_d_r;
  assign bus.ram_cs    = ram_cs_r;
  assign bus.ram_oe    = ram_oe_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.vid_q     = vid_q_r;
  assign bus.cpu_q     = cpu_q_r;
  assign bus.vid_valid = vid_valid_r;
  assign bus.cpu_valid = cpu_valid_r;
  assign bus.dma_ack   = dma_ack_r;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DMA_MAX_WAIT, default 15: arbitration slots a pending DMA may lose before it is promoted.
REQ-002 SHALL have port CLK_IN  in  1  system clock; single clock for all logic.
REQ-003 SHALL have port RESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port phi2  in  1  ULA phase; 1 = CPU phase, 0 = video phase.
REQ-005 SHALL have ports vid_req in 1, vid_ad in 16: ULA video fetch request (read-only) and address.
REQ-006 SHALL have ports vid_q out 8, vid_valid out 1: video read data and its 1-cycle valid strobe.
REQ-007 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_ad in 16, cpu_d in 8: CPU access request, write flag, address and write data.
REQ-008 SHALL have ports cpu_q out 8, cpu_valid out 1: CPU read data and completion strobe (reads and writes).
REQ-009 SHALL have ports dma_req in 1, dma_ad in 16, dma_d in 8, dma_ack out 1: tape-loader write request, address, data and completion strobe.
REQ-010 SHALL have ports ram_ad out 16, ram_d out 8, ram_q in 8, ram_cs out 1, ram_oe out 1, ram_we out 1: SRAM port.

Function
REQ-011 SHALL implement FSM states IDLE, ACC1, ACC2; each SRAM access occupies exactly ACC1 then ACC2.
REQ-012 SHALL treat requests as levels held by the requester until its valid/ack strobe; a request dropped before grant is not serviced.
REQ-013 SHALL arbitrate in IDLE and in ACC2; a winner in ACC2 enters ACC1 next cycle (back-to-back, no idle gap).
REQ-014 SHALL use priority vid > dma when phi2=0 (cpu_req ignored) and cpu > dma when phi2=1 (vid_req ignored).
REQ-015 SHALL promote DMA above CPU (never above video) when its wait counter equals DMA_MAX_WAIT.
REQ-016 SHALL increment the 4-bit saturating wait counter on each arbitration where dma_req=1 and DMA loses; clear it on DMA grant or dma_req=0.
REQ-017 SHALL latch the granted source's address, write flag and data at grant; the phi2 value at grant governs the whole access, even if phi2 changes mid-access.
REQ-018 SHALL drive ram_ad from the latched address and ram_cs=1 in ACC1 and ACC2.
REQ-019 SHALL drive ram_oe=1 in ACC1 and ACC2 for reads; ram_oe=0 for writes.
REQ-020 SHALL drive ram_we=1 in ACC2 only for writes; ram_d = latched data during write accesses.
REQ-021 SHALL drive ram_cs/oe/we=0 in IDLE; ram_ad and ram_d hold their last values.
REQ-022 SHALL register ram_q at the end of ACC2 into vid_q or cpu_q per owner, and pulse the matching vid_valid/cpu_valid/dma_ack for one cycle in the following cycle.
REQ-023 SHALL leave vid_q and cpu_q unchanged except on their own completed reads.
REQ-024 SHALL pulse cpu_valid for CPU writes, with cpu_q unchanged.
REQ-025 SHALL give the latency from grant to strobe as 3 cycles: ACC1, ACC2, strobe.
REQ-026 SHALL have at most one strobe asserted in any cycle.

Reset
REQ-027 SHALL, while RESETn=0, force state IDLE, ram_cs/oe/we=0, all strobes 0, vid_q=cpu_q=0x00, ram_ad=0x0000, ram_d=0x00, wait counter=0.
REQ-028 SHALL abort an in-flight access on reset with no strobe; the first arbitration is in the first cycle after RESETn rises.

Verification
REQ-029 SHALL pass: phi2=0, vid_req=1, vid_ad=0xBB80, ram_q=0x41 -> ram_oe=1 for 2 cycles at 0xBB80; vid_valid pulse with vid_q=0x41.
REQ-030 SHALL pass: phi2=1, cpu_req and dma_req both 1 -> CPU granted first; DMA next; dma_ack follows cpu_valid by exactly 2 cycles.
REQ-031 SHALL pass: phi2=1, cpu_req held continuously, dma_req=1, dma_ad=0x0501, dma_d=0x5A -> after 15 lost slots DMA wins; ram_we=1 one cycle with ram_d=0x5A at 0x0501.
REQ-032 SHALL pass: CPU write cpu_ad=0x0300, cpu_d=0xFF -> ram_we only in ACC2; ram_oe=0; cpu_valid pulse; cpu_q unchanged.
REQ-033 SHALL pass: RESETn low during ACC1 of a CPU read -> outputs 0 immediately, no cpu_valid; after release with cpu_req held, access restarts and completes.
REQ-034 SHALL pass: phi2 toggles 0->1 during a video ACC2 -> video access completes; CPU granted in the same ACC2 arbitration.
